// File: rtl/ram_pkg.sv
// Shared types and constants for the dual-port RAM with clear sweep.
package ram_pkg;

  // Clear sequencer states: IDLE serves user traffic, CLEAR sweeps zeros.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  // Same-address read/write collision modes.
  localparam int RD_FIRST = 32'sd0;
  localparam int WR_FIRST = 32'sd1;

endpackage : ram_pkg

// File: rtl/ram_clr_fsm.sv
// Clear sequencer: walks every address once, driving busy for the whole
// sweep. A reset parks the sequencer in CLEAR at address 0, so the array is
// always swept after reset is released.
module ram_clr_fsm
  import ram_pkg::*;
#(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic          busy,
  output logic [AW-1:0] sweep_addr
);

  localparam logic [AW-1:0] LAST_ADDR = '1;

  clr_state_e    state_r;
  logic [AW-1:0] addr_r;
  logic          busy_r;

  // Sweep state machine; clr is only honoured from IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_CLEAR;
      addr_r  <= '0;
      busy_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          addr_r <= '0;
          if (clr) begin
            state_r <= ST_CLEAR;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (addr_r == LAST_ADDR) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            addr_r  <= '0;
          end else begin
            state_r <= ST_CLEAR;
            busy_r  <= 1'b1;
            addr_r  <= addr_r + 1'b1;
          end
        end
        default: begin
          state_r <= ST_CLEAR;
          busy_r  <= 1'b1;
          addr_r  <= '0;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign sweep_addr = addr_r;

endmodule : ram_clr_fsm

// File: rtl/ram_dp_clr.sv
// Simple dual-port RAM (one write, one read port, single clock) with byte
// enables, 1- or 2-cycle read latency, selectable collision behaviour and a
// whole-array clear sweep. The storage array itself is never reset.
module ram_dp_clr
  import ram_pkg::*;
#(
  parameter int AW     = 7,
  parameter int DW     = 16,
  parameter int RD_LAT = 1,
  parameter int WMODE  = RD_FIRST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic [DW/8-1:0] wr_be,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [DW-1:0]   rd_data,
  output logic            rd_valid,
  input  logic            clr,
  output logic            busy
);

  localparam int DEPTH = 32'sd1 << AW;
  localparam int NB    = DW / 32'sd8;
  localparam bit LAT2  = (RD_LAT == 32'sd2);
  localparam bit WFIRST = (WMODE == WR_FIRST);

  // Replace the enabled bytes of old_w with those of new_w.
  function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0] old_w,
                                               input logic [DW-1:0] new_w,
                                               input logic [NB-1:0] be);
    logic [DW-1:0] m;
    m = old_w;
    for (int k = 0; k < NB; k++) begin
      if (be[k]) begin
        m[8*k +: 8] = new_w[8*k +: 8];
      end
    end
    return m;
  endfunction

  logic [DW-1:0] mem_r [0:DEPTH-1];

  logic          busy_s;
  logic [AW-1:0] sweep_addr_s;
  logic          wr_fire_s;
  logic          rd_fire_s;
  logic [DW-1:0] rd_word_s;
  logic          done_valid_s;
  logic [DW-1:0] done_data_s;

  logic          s1_valid_r;
  logic [DW-1:0] s1_data_r;
  logic          rd_valid_r;
  logic [DW-1:0] rd_data_r;

  ram_clr_fsm #(.AW(AW)) u_clr_fsm (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .busy       (busy_s),
    .sweep_addr (sweep_addr_s)
  );

  // User traffic is locked out for the whole sweep.
  assign wr_fire_s = wr_en & ~busy_s;
  assign rd_fire_s = rd_en & ~busy_s;

  // Word seen by a read launched this cycle, resolving a same-address write.
  always_comb begin
    rd_word_s = mem_r[rd_addr];
    if (WFIRST && wr_fire_s && (wr_addr == rd_addr)) begin
      rd_word_s = byte_merge(mem_r[rd_addr], wr_data, wr_be);
    end else begin
      rd_word_s = mem_r[rd_addr];
    end
  end

  // Storage update: the sweep owns the array while busy, else byte writes.
  always_ff @(posedge clk) begin
    if (busy_s) begin
      mem_r[sweep_addr_s] <= '0;
    end else if (wr_fire_s) begin
      mem_r[wr_addr] <= byte_merge(mem_r[wr_addr], wr_data, wr_be);
    end
  end

  // Select which stage completes a read this cycle for the chosen latency.
  always_comb begin
    done_valid_s = 1'b0;
    done_data_s  = '0;
    if (LAT2) begin
      done_valid_s = s1_valid_r;
      done_data_s  = s1_data_r;
    end else begin
      done_valid_s = rd_fire_s;
      done_data_s  = rd_word_s;
    end
  end

  // Read pipeline; in-flight reads finish even after a clear starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= '0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= '0;
    end else begin
      s1_valid_r <= rd_fire_s;
      if (rd_fire_s) begin
        s1_data_r <= rd_word_s;
      end
      rd_valid_r <= done_valid_s;
      if (done_valid_s) begin
        rd_data_r <= done_data_s;
      end
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign busy     = busy_s;

endmodule : ram_dp_clr

// File: doc/ram_dp_clr.md
RAM_DP_CLR -- requirements
Module: ram_dp_clr

Interface
REQ-001 SHALL have parameter AW, default 7, address width; depth = 2**AW words.
REQ-002 SHALL have parameter DW, default 16, data width; multiple of 8.
REQ-003 SHALL have parameter RD_LAT, default 1, read latency in cycles; legal values 1 or 2.
REQ-004 SHALL have parameter WMODE, default 0, same-address collision mode; 0 = read-first, 1 = write-first.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on the rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port wr_en, input, 1, write request.
REQ-008 SHALL have port wr_addr, input, AW, write address.
REQ-009 SHALL have port wr_data, input, DW, write data.
REQ-010 SHALL have port wr_be, input, DW/8, byte enables; bit k covers wr_data[8k+7:8k].
REQ-011 SHALL have port rd_en, input, 1, read request.
REQ-012 SHALL have port rd_addr, input, AW, read address.
REQ-013 SHALL have port rd_data, output, DW, read data.
REQ-014 SHALL have port rd_valid, output, 1, one-cycle strobe qualifying rd_data.
REQ-015 SHALL have port clr, input, 1, request to zero the whole array.
REQ-016 SHALL have port busy, output, 1, clear sweep in progress.

Function
REQ-017 SHALL write only the bytes with wr_be=1 at wr_addr on a clock edge where wr_en=1 and busy=0; other bytes are unchanged.
REQ-018 SHALL sample rd_en/rd_addr at an edge with busy=0 and present data with rd_valid=1 exactly RD_LAT cycles later.
REQ-019 SHALL hold rd_data at its last value when no read completes, with rd_valid=0.
REQ-020 SHALL accept back-to-back reads at one per cycle at either RD_LAT.
REQ-021 SHALL, on a same-cycle write and read to the same address, return pre-write data when WMODE=0, or the byte-merged post-write word when WMODE=1.
REQ-022 SHALL implement the clear FSM with two states: IDLE and CLEAR.
REQ-023 SHALL enter CLEAR on the first edge after rst deasserts.
REQ-024 SHALL, in CLEAR, write zero to one address per cycle from 0 to 2**AW-1 (2**AW cycles total), then go to IDLE.
REQ-025 SHALL go from IDLE to CLEAR on the edge after clr=1 is sampled.
REQ-026 SHALL ignore clr while in CLEAR; the sweep neither restarts nor extends.
REQ-027 SHALL drive busy=1 throughout CLEAR, ignore wr_en/rd_en while busy=1, and start no new read.
REQ-028 SHALL complete a read already in the RD_LAT pipeline when clr is accepted, returning pre-clear data.

Reset
REQ-029 SHALL, while rst=0, force rd_data=0, rd_valid=0, busy=1, FSM=CLEAR, sweep address=0, and flush the read pipeline.
REQ-030 SHALL NOT reset the storage array; contents are defined only after the sweep.
REQ-031 SHALL restart the sweep from address 0 after rst is asserted mid-sweep and released.

Structure
REQ-032 SHALL place the FSM state enum and the collision-mode constants (RD_FIRST, WR_FIRST) in shared package ram_pkg.
REQ-033 SHALL implement the clear sequencer (FSM, sweep counter, busy) as sub-module ram_clr_fsm; storage and the read pipeline stay in ram_dp_clr.

Verification
All scenarios use AW=7 and DW=16 unless stated.
REQ-034 SHALL check: release rst at t0 -> busy=1 for exactly 128 cycles; then reads of addresses 0, 64 and 127 return 0x0000.
REQ-035 SHALL check: write 0xABCD to address 5 with be=11, then write 0x1234 with be=01 -> read of address 5 gives 0xAB34 with rd_valid one cycle after rd_en (RD_LAT=1), and two cycles after (RD_LAT=2).
REQ-036 SHALL check: address 9 holds 0x1111; same-cycle write of 0x2222 (be=11) and read of address 9 -> 0x1111 when WMODE=0, 0x2222 when WMODE=1; a following read gives 0x2222 in both modes.
REQ-037 SHALL check: clr pulse while address 3 holds 0x5A5A -> busy rises the next cycle and lasts 128 cycles; a wr_en issued during busy is dropped; afterwards address 3 reads 0x0000; a second clr at cycle 50 of the sweep has no effect.
REQ-038 SHALL check: rst asserted at cycle 60 of the sweep -> rd_valid=0 and busy=1 immediately; after release, busy lasts a full 128 cycles.
REQ-039 SHALL check: 128 consecutive reads issued one per cycle at RD_LAT=2 -> 128 contiguous rd_valid pulses with data matching a reference model.
